node_table_loader: RTL and testbench

- Writer side of the decision-tree node memory; the tree controller only reads this memory.
- Accepts a byte stream from the host/config link, one frame per channel.
- Packs each frame into 24-bit node words and writes them at address ch*MAX_CLUSTERS + node.
- Holds the controller off (busy) while a table is being rewritten.

---
 rtl/node_table_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_node_table_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_table_loader.sv
// node_table_loader: packs a per-channel byte stream into node words and writes the decision-tree node memory.
// Optional macro NODE_LOADER_CHECKSUM_EN: trailing XOR byte, words staged in a shadow buffer until it matches.
module node_table_loader #(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int MAX_CLUSTERS    = 5,
    parameter int CHANNEL_COUNT   = 16,
    parameter int WORD_BITS       = 24,
    localparam int ADDR_W         = $clog2(MAX_CLUSTERS * CHANNEL_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_a,
    output logic [WORD_BITS-1:0] mem_d,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           fsm_state
);

    localparam int BPW      = (WORD_BITS + 7) / 8;
    localparam int SHIFT_W  = BPW * 8;
    localparam int TOP      = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
    localparam int USED     = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
    localparam int LOW_PAD  = TOP - USED + 1;
    localparam int CH_W     = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int BC_W     = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int NC_W     = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1;
`ifdef NODE_LOADER_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif
    localparam int DRAIN_BYTES = MAX_CLUSTERS * BPW + CSUM_BYTES;
    localparam int DC_W        = (DRAIN_BYTES > 1) ? $clog2(DRAIN_BYTES) : 1;

    // Bits below the bias field carry no meaning and are always written as zero.
    localparam logic [WORD_BITS-1:0] KEEP_MASK = {WORD_BITS{1'b1}} << LOW_PAD;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BYTE   = 3'd1,
        WRITE  = 3'd2,
        FIN    = 3'd3,
        DRAIN  = 3'd4,
        CSUM   = 3'd5,
        COMMIT = 3'd6
    } state_t;

    state_t state, state_nx;

    logic                 rdy_en;
    logic [CH_W-1:0]      ch;
    logic [BC_W-1:0]      byte_cnt;
    logic [NC_W-1:0]      node_cnt;
    logic [DC_W-1:0]      drain_cnt;
    logic [SHIFT_W-1:0]   word_sr;
    logic                 accept;
    logic                 hdr_ok;
    logic                 byte_last;
    logic                 node_last;
    logic                 drain_last;
    logic [ADDR_W-1:0]    wr_addr;
    logic [WORD_BITS-1:0] packed_word;

    // Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
    // in_valid may drop at any time (stall), in_ready depends only on state, never on in_valid.
    assign in_ready = rdy_en && ((state == IDLE) || (state == BYTE) ||
                                 (state == DRAIN) || (state == CSUM));
    assign accept   = in_valid && in_ready;

    assign hdr_ok      = (32'(in_data) < 32'(CHANNEL_COUNT));
    assign byte_last   = (byte_cnt == BC_W'(BPW - 1));
    assign node_last   = (node_cnt == NC_W'(MAX_CLUSTERS - 1));
    assign drain_last  = (drain_cnt == DC_W'(DRAIN_BYTES - 1));
    assign wr_addr     = ADDR_W'(ch) * ADDR_W'(MAX_CLUSTERS) + ADDR_W'(node_cnt);
    assign packed_word = word_sr[WORD_BITS-1:0] & KEEP_MASK;
    assign fsm_state   = state;

`ifdef NODE_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
    logic [WORD_BITS-1:0] shadow [MAX_CLUSTERS];
    logic                 csum_ok;

    assign csum_ok = (csum == in_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
            for (int i = 0; i < MAX_CLUSTERS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (accept && (state == IDLE)) begin
                csum <= in_data;
            end else if (accept && (state == BYTE)) begin
                csum <= csum ^ in_data;
            end
            if (state == WRITE) begin
                shadow[node_cnt] <= packed_word;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en    <= 1'b0;
            ch        <= '0;
            byte_cnt  <= '0;
            node_cnt  <= '0;
            drain_cnt <= '0;
            word_sr   <= '0;
            error     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        byte_cnt  <= '0;
                        node_cnt  <= '0;
                        drain_cnt <= '0;
                        if (hdr_ok) begin
                            ch    <= in_data[CH_W-1:0];
                            error <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                BYTE: begin
                    if (accept) begin
                        word_sr  <= {word_sr[SHIFT_W-9:0], in_data};
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    byte_cnt <= '0;
                    node_cnt <= node_last ? '0 : node_cnt + 1'b1;
                end
                DRAIN: begin
                    if (accept) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
`ifdef NODE_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept && !csum_ok) begin
                        error <= 1'b1;
                    end
                end
                COMMIT: begin
                    node_cnt <= node_last ? '0 : node_cnt + 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        mem_a    = '0;
        mem_d    = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = hdr_ok ? BYTE : DRAIN;
                end
            end
            BYTE: begin
                busy = 1'b1;
                if (accept && byte_last) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
`ifdef NODE_LOADER_CHECKSUM_EN
                state_nx = node_last ? CSUM : BYTE;
`else
                mem_we   = 1'b1;
                mem_a    = wr_addr;
                mem_d    = packed_word;
                state_nx = node_last ? FIN : BYTE;
`endif
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (accept && drain_last) begin
                    state_nx = IDLE;
                end
            end
`ifdef NODE_LOADER_CHECKSUM_EN
            CSUM: begin
                busy = 1'b1;
                if (accept) begin
                    state_nx = csum_ok ? COMMIT : IDLE;
                end
            end
            COMMIT: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_a  = wr_addr;
                mem_d  = shadow[node_cnt];
                if (node_last) begin
                    state_nx = FIN;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_node_table_loader.sv
// Scoreboard bench for node_table_loader: directed frames, expected writes queued, monitor compares on mem_we.
// Builds with or without NODE_LOADER_CHECKSUM_EN.
module tb_node_table_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [6:0]  mem_a;
    logic [23:0] mem_d;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  fsm_state;

    // queue entry: {last_word_of_frame, addr[6:0], data[23:0]}
    logic [31:0] exp_q[$];
    logic [7:0]  pay[15];
    int          total;
    int          bad;
    int          done_cnt;
    logic        prev_last;
`ifdef NODE_LOADER_CHECKSUM_EN
    logic [7:0]  csum_flip;
`endif

    node_table_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int gap);
`ifdef NODE_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = hdr;
`endif
        send_byte(hdr);
        for (int i = 0; i < 15; i++) begin
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_byte(pay[i]);
`ifdef NODE_LOADER_CHECKSUM_EN
            x = x ^ pay[i];
`endif
        end
`ifdef NODE_LOADER_CHECKSUM_EN
        send_byte(x ^ csum_flip);
`endif
    endtask

    task automatic push_exp(input int addr, input logic [23:0] data, input logic last);
        exp_q.push_back({last, 7'(addr), data});
    endtask

    task automatic settle();
        int budget;
        budget = 0;
        @(negedge clk);
        while (busy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (busy) begin
            check("busy_timeout", 32'(busy), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        logic        nxt_last;
        nxt_last = 1'b0;
        if (reset) begin
            if (mem_we) begin
                check("we_in_ready_low", 32'(in_ready), 32'd0);
                check("we_busy_high", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_a, mem_d);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_a), 32'(e[30:24]));
                    check("wr_data", 32'(mem_d), 32'(e[23:0]));
                    nxt_last = e[31];
                end
            end
            if (done) begin
                done_cnt++;
                check("done_in_ready_low", 32'(in_ready), 32'd0);
                check("done_after_last_we", 32'(prev_last), 32'd1);
            end else if (prev_last) begin
                check("done_after_last_we", 32'(done), 32'd1);
            end
        end
        prev_last = nxt_last;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [23:0] t1_words[5];
        t1_words = '{24'hC00002, 24'hC10002, 24'hC20002, 24'hC30002, 24'hC40002};
        total     = 0;
        bad       = 0;
        done_cnt  = 0;
        prev_last = 1'b0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
`ifdef NODE_LOADER_CHECKSUM_EN
        csum_flip = 8'h00;
`endif

        // reset values
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_mem_d", 32'(mem_d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        #1;
        check("in_ready_before_first_clk", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_first_clk", 32'(in_ready), 32'd1);

        // frame for channel 2: addresses 10..14
        for (int n = 0; n < 5; n++) begin
            pay[3*n]   = 8'hC0 | 8'(n);
            pay[3*n+1] = 8'h00;
            pay[3*n+2] = 8'h02;
            push_exp(10 + n, t1_words[n], n == 4);
        end
        send_byte(8'h02);
        check("busy_after_header", 32'(busy), 32'd1);
        for (int i = 0; i < 15; i++) send_byte(pay[i]);
        settle();
        check("done_count_ch2", 32'(done_cnt), 32'd1);
        check("busy_low_after_ch2", 32'(busy), 32'd0);

        // header out of range: drained, error set, no writes
        send_frame(8'h10, 0);
        check("bad_hdr_busy_low", 32'(busy), 32'd0);
        check("bad_hdr_error", 32'(error), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bad_hdr_no_done", 32'(done_cnt), 32'd1);

        // channel 0 clears error; low bit of each word forced to 0
        for (int n = 0; n < 5; n++) begin
            pay[3*n]   = 8'(n);
            pay[3*n+1] = 8'hA5;
            pay[3*n+2] = 8'h5B;
        end
        push_exp(0, 24'h00A55A, 1'b0);
        push_exp(1, 24'h01A55A, 1'b0);
        push_exp(2, 24'h02A55A, 1'b0);
        push_exp(3, 24'h03A55A, 1'b0);
        push_exp(4, 24'h04A55A, 1'b1);
        send_byte(8'h00);
        check("good_hdr_clears_error", 32'(error), 32'd0);
        for (int i = 0; i < 15; i++) send_byte(pay[i]);
        settle();
        check("done_count_ch0", 32'(done_cnt), 32'd2);

        // last channel: addresses 75..79, all-ones words
        for (int i = 0; i < 15; i++) pay[i] = 8'hFF;
        for (int n = 0; n < 5; n++) push_exp(75 + n, 24'hFFFFFE, n == 4);
        send_frame(8'h0F, 0);
        settle();
        check("done_count_ch15", 32'(done_cnt), 32'd3);

        // channel 1 with in_valid toggling every other cycle
        for (int n = 0; n < 5; n++) begin
            pay[3*n]   = 8'hC0 | 8'(n);
            pay[3*n+1] = 8'h00;
            pay[3*n+2] = 8'h02;
            push_exp(5 + n, t1_words[n], n == 4);
        end
        send_frame(8'h01, 1);
        settle();
        check("done_count_gap", 32'(done_cnt), 32'd4);

        // reset in the middle of a channel 4 frame after 7 payload bytes
`ifndef NODE_LOADER_CHECKSUM_EN
        push_exp(20, t1_words[0], 1'b0);
        push_exp(21, t1_words[1], 1'b0);
`endif
        send_byte(8'h04);
        for (int i = 0; i < 7; i++) send_byte(pay[i]);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_a", 32'(mem_a), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_writes_issued", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) push_exp(15 + n, t1_words[n], n == 4);
        send_frame(8'h03, 0);
        settle();
        check("done_count_after_rst", 32'(done_cnt), 32'd5);

`ifdef NODE_LOADER_CHECKSUM_EN
        // corrupted checksum: nothing written, error set
        csum_flip = 8'h01;
        send_frame(8'h07, 0);
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_busy", 32'(busy), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("csum_bad_no_done", 32'(done_cnt), 32'd5);
        csum_flip = 8'h00;
        for (int n = 0; n < 5; n++) push_exp(30 + n, t1_words[n], n == 4);
        send_frame(8'h06, 0);
        check("csum_good_error_clear", 32'(error), 32'd0);
        settle();
        check("csum_good_done", 32'(done_cnt), 32'd6);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
